// File: rtl/jtvigil_scr2_fetch.sv
// jtvigil_scr2_fetch
//   Background (scroll layer 2) pixel fetch for the Vigilante video board.
//   A two-stage pixel pipeline turns the video counters and horizontal scroll
//   into an 11-bit scrolled position, and a small two-word buffer (cur/nxt)
//   feeds 4bpp pixels out of 32-bit ROM words.  A fetch FSM keeps the word
//   for the next column (in scan direction) prefetched into nxt.
//
// Ports
//   clk       system clock (48 MHz), all logic on the rising edge
//   rst       synchronous active-high reset
//   pxl_cen   pixel clock enable (6 MHz), one clk wide
//   flip      screen flip: mirrors h and v, reverses scan direction
//   h, v      current horizontal / vertical video counters (9 bit)
//   scrpos    horizontal scroll position in pixels (11 bit, wraps)
//   rom_addr  ROM word address {2'b00, row, column}
//   rom_cs    ROM request, held until the word is accepted
//   rom_ok    ROM data valid
//   rom_data  ROM word, eight 4bpp pixels, pixel n = bits [4n+3:4n]
//   pxl       background colour index, 0 = transparent
module jtvigil_scr2_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        flip,
  input  logic [8:0]  h,
  input  logic [8:0]  v,
  input  logic [10:0] scrpos,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic [3:0]  pxl
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nx;
  logic [10:0] e_r;
  logic [7:0]  row_r;
  logic [8:0]  v_last;
  logic [8:0]  h_x;
  logic [7:0]  col, tgt;

  logic [31:0] cur_data, nxt_data;
  logic [7:0]  cur_tag, nxt_tag, pend_tag;
  logic        cur_vld, nxt_vld;
  logic        ok_skip;

  logic        cur_hit, nxt_hit, tgt_have, promote, new_line, fetch_done;
  logic        cs_nx, skip_nx;
  logic [17:0] addr_nx;
  logic [7:0]  pend_nx;

  function automatic logic [3:0] nib_sel(input logic [31:0] w, input logic [2:0] n);
    return w[{n, 2'b00} +: 4];
  endfunction

  assign h_x      = flip ? ~h : h;
  assign col      = e_r[10:3];
  assign tgt      = flip ? col - 8'd1 : col + 8'd1;
  assign cur_hit  = cur_vld && (cur_tag == col);
  assign nxt_hit  = nxt_vld && (nxt_tag == col);
  assign tgt_have = (cur_vld && (cur_tag == tgt)) || (nxt_vld && (nxt_tag == tgt));
  // Promotion is not gated by pxl_cen: once the scrolled position enters the
  // column held in nxt, that word moves to cur straight away so the prefetch
  // of the following column cannot overwrite it before it is displayed.
  assign promote    = !cur_hit && nxt_hit;
  assign new_line   = pxl_cen && (v != v_last);
  assign fetch_done = (state == WAIT) && !ok_skip && rom_ok;

  // ---- stage 1: scrolled position and row ----
  always_ff @(posedge clk) begin
    if (rst) begin
      e_r    <= 11'd0;
      row_r  <= 8'd0;
      v_last <= 9'd0;
    end else if (pxl_cen) begin
      e_r    <= scrpos + {2'b00, h_x};
      row_r  <= v[7:0] ^ {8{flip}};
      v_last <= v;
    end
  end

  // ---- stage 2: pixel output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pxl <= 4'd0;
    end else if (pxl_cen) begin
      pxl <= cur_hit ? nib_sel(cur_data, e_r[2:0]) :
             nxt_hit ? nib_sel(nxt_data, e_r[2:0]) : 4'd0;
    end
  end

  // Buffer tags and valid flags.  Statement order gives the priorities:
  // a new line clears both flags, and a completing fetch wins nxt even when
  // the old nxt is being promoted on the same clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_vld <= 1'b0;
      nxt_vld <= 1'b0;
      cur_tag <= 8'd0;
      nxt_tag <= 8'd0;
    end else begin
      if (promote) begin
        cur_tag <= nxt_tag;
        cur_vld <= 1'b1;
        nxt_vld <= 1'b0;
      end
      if (new_line) begin
        cur_vld <= 1'b0;
        nxt_vld <= 1'b0;
      end
      if (fetch_done) begin
        nxt_tag <= pend_tag;
        nxt_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (promote)    cur_data <= nxt_data;
    if (fetch_done) nxt_data <= rom_data;
  end

  // ---- fetch FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= 18'd0;
      pend_tag <= 8'd0;
      ok_skip  <= 1'b0;
    end else begin
      state    <= state_nx;
      rom_cs   <= cs_nx;
      rom_addr <= addr_nx;
      pend_tag <= pend_nx;
      ok_skip  <= skip_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cs_nx    = rom_cs;
    addr_nx  = rom_addr;
    pend_nx  = pend_tag;
    skip_nx  = ok_skip;
    case (state)
      IDLE: begin
        cs_nx = 1'b0;
        if (!tgt_have) begin
          addr_nx  = {2'b00, row_r, tgt};
          cs_nx    = 1'b1;
          pend_nx  = tgt;
          // rom_ok may still be high from the previous request
          skip_nx  = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (ok_skip) begin
          skip_nx = 1'b0;
        end else if (rom_ok) begin
          cs_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtvigil_scr2_fetch.sv
module tb_jtvigil_scr2_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen;
  logic        flip;
  logic [8:0]  h, v;
  logic [10:0] scrpos;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok = 1'b0;
  logic [31:0] rom_data;
  logic [3:0]  pxl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtvigil_scr2_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .flip     (flip),
    .h        (h),
    .v        (v),
    .scrpos   (scrpos),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_ok   (rom_ok),
    .rom_data (rom_data),
    .pxl      (pxl)
  );

  // ROM model: ok after 4 clk of rom_cs (plus extra stall), or always high
  logic always_ok = 1'b0;
  int   extra = 0;
  int   cnt = 0;

  always @(posedge clk) begin
    if (rom_cs !== 1'b1) begin
      cnt    <= 0;
      rom_ok <= always_ok;
    end else begin
      cnt    <= cnt + 1;
      rom_ok <= always_ok || (cnt >= 3 + extra);
    end
  end

  assign rom_data = 32'h76543210 + {24'd0, rom_addr[7:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Request monitor: address stability, last request address, pulse width
  logic        prev_cs = 1'b0;
  logic [17:0] prev_addr = 18'd0;
  logic [17:0] last_req = 18'd0;
  int          run_len = 0;
  int          last_len = 0;

  always @(negedge clk) begin
    if (rom_cs === 1'b1 && prev_cs === 1'b1)
      chk("addr_hold", 32'(rom_addr), 32'(prev_addr));
    if (rom_cs === 1'b1 && prev_cs !== 1'b1)
      last_req <= rom_addr;
    if (rom_cs === 1'b1)
      run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_len <= run_len;
      run_len  <= 0;
    end
    prev_cs   <= rom_cs;
    prev_addr <= rom_addr;
  end

  function automatic logic [10:0] calc_e(input logic [10:0] sp, input logic fl,
                                         input logic [8:0] hh);
    logic [8:0] hx;
    hx = fl ? ~hh : hh;
    return sp + {2'b00, hx};
  endfunction

  function automatic logic [3:0] exp_pix(input logic [10:0] e);
    logic [31:0] w;
    w = 32'h76543210 + {24'd0, e[10:3]};
    return w[{e[2:0], 2'b00} +: 4];
  endfunction

  logic [3:0] exp_q = 4'd0;
  bit         chk_q = 1'b0;
  logic [3:0] hold_q;

  // One pixel period: 7 clk without enable then one pxl_cen clk.  The pixel
  // checked after the enable belongs to the h given on the previous call.
  task automatic pix(input logic [8:0] hh, input bit do_chk, input logic [3:0] expv);
    h = hh;
    pxl_cen = 1'b0;
    hold_q = pxl;
    repeat (7) begin @(posedge clk); #1; end
    chk("pxl_hold", 32'(pxl), 32'(hold_q));
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    if (chk_q) chk("pxl", 32'(pxl), 32'(exp_q));
    exp_q = expv;
    chk_q = do_chk;
  endtask

  task automatic sweep(input int h0, input int n, input int chk_from);
    logic [8:0] hh;
    for (int i = 0; i < n; i++) begin
      hh = 9'(h0 + i);
      pix(hh, (h0 + i) >= chk_from, exp_pix(calc_e(scrpos, flip, hh)));
    end
  endtask

  logic [3:0] lit31 [9] = '{4'd5, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; flip = 1'b0; h = 9'd5; v = 9'd10; scrpos = 11'd0;
    repeat (3) begin @(posedge clk); #1; end
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    chk("rst_pxl", 32'(pxl), 32'd0);
    chk("rst_cs", 32'(rom_cs), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_cs", 32'(rom_cs), 32'd1);
    chk("first_addr", 32'(rom_addr), 32'h00001);

    // basic line, row 10
    sweep(0, 48, 8);
    chk("req_row10", 32'(last_req), 32'h00A06);

    // scroll wrap 2047 -> 0
    scrpos = 11'd2029;
    sweep(0, 16, 3);
    scrpos = 11'd2045;
    for (int i = 0; i < 9; i++) pix(9'(i), 1'b1, lit31[i]);

    // flipped screen, descending nibbles, prefetch c-1
    flip = 1'b1;
    scrpos = 11'd0;
    sweep(0, 32, 8);
    chk("req_flip", 32'(last_req), 32'h0F53B);

    // ROM stall across a column boundary after a new line
    flip = 1'b0;
    sweep(0, 15, 8);
    extra = 20;
    v = 9'd11;
    pix(9'd15, 1'b1, 4'd0);
    pix(9'd16, 1'b1, 4'd0);
    chk("stall_cs", 32'(rom_cs), 32'd1);
    chk("stall_addr", 32'(rom_addr), 32'h00B02);
    pix(9'd17, 1'b1, 4'd0);
    pix(9'd18, 1'b1, exp_pix(calc_e(scrpos, flip, 9'd18)));
    extra = 0;
    sweep(19, 13, 19);

    // rom_ok stuck high: one-clk ignore, one word per request
    always_ok = 1'b1;
    v = 9'd12;
    sweep(32, 24, 40);
    chk("ok_high_width", 32'(last_len), 32'd2);
    chk("req_row12", 32'(last_req), 32'h00C07);

    // reset pulse during WAIT
    always_ok = 1'b0;
    extra = 20;
    v = 9'd13;
    pix(9'd56, 1'b0, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_cs", 32'(rom_cs), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_cs", 32'(rom_cs), 32'd0);
    chk("rst_wait_pxl", 32'(pxl), 32'd0);
    chk("rst_wait_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    extra = 0;
    @(posedge clk); #1;
    chk("resume_cs", 32'(rom_cs), 32'd1);
    chk("resume_addr", 32'(rom_addr), 32'h00001);
    sweep(0, 24, 8);
    pix(9'd24, 1'b0, 4'd0);
    chk("req_row13", 32'(last_req), 32'h00D03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtvigil_scr2_fetch.md
JTVIGIL_SCR2_FETCH -- requirements
Module: jtvigil_scr2_fetch

Interface
REQ-001 SHALL have port: clk  input  1  system clock (48 MHz); all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: pxl_cen  input  1  pixel clock enable (6 MHz), one clk wide.
REQ-004 SHALL have port: flip  input  1  screen flip.
REQ-005 SHALL have ports: h  input  9  and v  input  9; these carry the current horizontal and vertical video counters.
REQ-006 SHALL have port: scrpos  input  11  horizontal scroll position, in pixels.
REQ-007 SHALL have port: rom_addr  output  18  ROM word address.
REQ-008 SHALL have ports: rom_cs  output  1  (ROM request) and rom_ok  input  1  (data valid).
REQ-009 SHALL have port: rom_data  input  32  one ROM word, eight 4bpp pixels; pixel n = bits [4n+3:4n].
REQ-010 SHALL have port: pxl  output  4  background pixel colour index; 0 means transparent.

Function
REQ-011 SHALL compute at each pxl_cen stage-1 register e_r = (scrpos + {2'b0, flip ? ~h : h}) mod 2048 (11-bit wrap), plus row_r = v[7:0] ^ {8{flip}}.
REQ-012 SHALL define column c = e_r[10:3], direction d = flip ? -1 : +1, and prefetch target t = (c + d) mod 256 (8-bit wrap, 255+1 -> 0, 0-1 -> 255).
REQ-013 SHALL hold two word buffers, cur and nxt, each with an 8-bit column tag and a valid flag.
REQ-014 SHALL produce stage-2 output at each pxl_cen: if cur is valid and cur tag == c, pxl = cur nibble e_r[2:0]; otherwise, if nxt is valid and nxt tag == c, pxl = nxt nibble e_r[2:0] and nxt is promoted; otherwise pxl = 0.
REQ-015 SHALL perform promotion as: cur <= nxt (data, tag, valid=1), nxt_valid <= 0.
REQ-016 SHALL make latency h -> pxl exactly 2 pxl_cen; pxl SHALL change only on pxl_cen.
REQ-017 SHALL run the fetch FSM with states IDLE and WAIT, evaluated every clk (not gated by pxl_cen).
REQ-018 SHALL, in IDLE, when !(nxt_valid && nxt tag == t) and !(cur_valid && cur tag == t), drive rom_addr = {2'b00, row_r, t}, set rom_cs = 1, latch t as pending tag, and go to WAIT; otherwise remain in IDLE with rom_cs = 0.
REQ-019 SHALL hold rom_addr and rom_cs stable throughout WAIT.
REQ-020 SHALL ignore rom_ok on the first clk after rom_cs rises, because the previous request's ok may still be high.
REQ-021 SHALL, in WAIT on rom_ok after the ignore cycle, write rom_data to nxt with the pending tag and valid = 1, drop rom_cs on the next clk, and return to IDLE.
REQ-022 SHALL, if promotion and fetch completion coincide on the same clk, copy the old nxt to cur and let the fetched word win for nxt (nxt_valid = 1).
REQ-023 SHALL complete a fetch whose target went stale during WAIT (scroll jump, new line); the FSM re-evaluates in IDLE.
REQ-024 SHALL NOT request the next fetch before a one-clk IDLE gap after each completion.
REQ-025 SHALL flush both valid flags when v changes (new line, detected on pxl_cen); a pending fetch SHALL still complete.
REQ-026 SHALL wrap the scroll position mod 2048, with column 255 adjacent to column 0.

Reset
REQ-027 SHALL, while rst = 1: pxl = 0, rom_cs = 0, rom_addr = 0, FSM = IDLE, cur/nxt valid = 0, tags = 0, e_r = 0, row_r = 0.
REQ-028 SHALL, on rst mid-WAIT, abandon the request (rom_cs = 0 next clk) and ignore any later rom_ok.
REQ-029 SHALL emit the first fetch no earlier than the first clk after rst deasserts.

Verification
REQ-030 SHALL cover: flip = 0, scrpos = 0, v = 10, ROM model with rom_ok after 4 clk returning word = 32'h76543210 + column -> rom_addr = {2'b00, 8'd10, col}, and once steady pxl cycles 0,1,...,7 per column two pxl_cen after h.
REQ-031 SHALL cover: scrpos = 2045, h sweeping 0..8 -> e_r = 2045, 2046, 2047, 0, ...; column 255 then 0 with no zero gap in steady state.
REQ-032 SHALL cover: flip = 1, h = 0, scrpos = 0 -> e_r = 511, row_r = ~v[7:0], nibble order descending 7..0, prefetch target c-1.
REQ-033 SHALL cover: rom_ok held low for 20 clk while the group boundary passes -> pxl = 0 for the unfetched pixels, then correct pixels resume; rom_cs stays high with constant rom_addr throughout the stall.
REQ-034 SHALL cover: rom_ok held high continuously -> it is ignored on the first clk after rom_cs rises, and exactly one word is captured per request.
REQ-035 SHALL cover: rst pulsed for 1 clk during WAIT -> rom_cs = 0 and pxl = 0 next clk, no buffer write, and normal fetch resumes afterwards.
